// File: rtl/seq_alu.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative MULT/DIV
// (one bit per clock) into HI/LO, with a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;
    // a: multiplicand / divisor; b: multiplier / dividend shifting out, quotient shifting in;
    // acc: running product high half / partial remainder
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;

    logic               s1, s2, is_signed;
    logic [WIDTH-1:0]   abs1, abs2, op_a, op_b;
    logic [WIDTH-1:0]   alu_res;

    logic [WIDTH:0]     msum;
    logic [WIDTH-1:0]   mul_acc, mul_b;
    logic [2*WIDTH-1:0] prod, prod_s;

    logic [WIDTH:0]     dshift, ddiff;
    logic               dge;
    logic [WIDTH-1:0]   div_acc, div_b, quo, rem;

    logic               last_iter;

    assign s1   = data1[WIDTH-1];
    assign s2   = data2[WIDTH-1];
    assign abs1 = s1 ? -data1 : data1;
    assign abs2 = s2 ? -data2 : data2;
    assign is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign op_a = is_signed ? abs1 : data1;
    assign op_b = is_signed ? abs2 : data2;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = data1 + data2;
            OP_SUB:  alu_res = data1 - data2;
            OP_OR:   alu_res = data1 | data2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
            OP_AND:  alu_res = data1 & data2;
            OP_XOR:  alu_res = data1 ^ data2;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, data1 < data2};
            OP_NOR:  alu_res = ~(data1 | data2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand into the high half when the current multiplier bit is set,
    // then shift the whole {acc,b} product right by one.
    always_comb begin
        msum    = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_acc = msum[WIDTH:1];
        mul_b   = {msum[0], b_q[WIDTH-1:1]};
        prod    = {mul_acc, mul_b};
        prod_s  = neg_q ? -prod : prod;
    end

    // Restoring step: partial remainder is always < divisor, so bit WIDTH of the
    // difference is a clean borrow flag.
    always_comb begin
        dshift  = {acc_q, b_q[WIDTH-1]};
        ddiff   = dshift - {1'b0, a_q};
        dge     = ~ddiff[WIDTH];
        div_acc = dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
        div_b   = {b_q[WIDTH-2:0], dge};
        quo     = neg_q  ? -div_b   : div_b;
        rem     = rneg_q ? -div_acc : div_acc;
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (alu_op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = op_a;
                            b_d     = op_b;
                            acc_d   = '0;
                            neg_d   = is_signed & (s1 ^ s2);
                            rneg_d  = 1'b0;
                            cnt_d   = '0;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (data2 == '0) begin
                                hi_d     = data1;
                                lo_d     = '1;
                                result_d = '1;
                                zero_d   = 1'b0;
                                dbz_d    = 1'b1;
                                done_d   = 1'b1;
                            end else begin
                                a_d     = op_b;
                                b_d     = op_a;
                                acc_d   = '0;
                                neg_d   = is_signed & (s1 ^ s2);
                                rneg_d  = is_signed & s1;
                                cnt_d   = '0;
                                state_d = S_DIV;
                            end
                        end
                        default: begin
                            result_d = alu_res;
                            zero_d   = (alu_res == '0);
                            dbz_d    = 1'b0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_acc;
                b_d   = mul_b;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    hi_d     = prod_s[2*WIDTH-1:WIDTH];
                    lo_d     = prod_s[WIDTH-1:0];
                    result_d = prod_s[WIDTH-1:0];
                    zero_d   = (prod_s[WIDTH-1:0] == '0);
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            S_DIV: begin
                acc_d = div_acc;
                b_d   = div_b;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    hi_d     = rem;
                    lo_d     = quo;
                    result_d = quo;
                    zero_d   = (quo == '0);
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the datapath combinational ALU.
- Adds unsigned compare, iterative multiply/divide with HI/LO registers, and a start/busy/done handshake.
- Sits in the EX stage. The pipeline stalls on `busy`.
- Single-cycle ops complete in 1 clock; MULT/DIV take WIDTH clocks.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, even).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge while busy=0.
- alu_op  input  4  operation code (below).
- data1  input  WIDTH  operand A / dividend / multiplicand.
- data2  input  WIDTH  operand B / divisor / multiplier.
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle pulse: result/hi/lo valid.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- div_by_zero  output  1  registered flag; set with done of a DIV/DIVU whose data2 = 0.

Behaviour:
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 OR, 0011 SLT (signed), 0100 AND, 0101 XOR, 0110 SLTU, 0111 NOR.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1100 MFHI, 1101 MFLO.
  - All others: result = 0.
- Reset (rst_n=0, asynchronous): busy=0, done=0, result=0, zero=1, hi=0, lo=0, div_by_zero=0. FSM → IDLE, counter=0.
- Reset mid-operation aborts the op immediately: no done, HI/LO cleared.
- FSM states: IDLE, MUL, DIV.
  - IDLE, start=1, single-cycle op (incl. MFHI/MFLO, undefined): at edge E0 register result/zero; done=1 for the following cycle; stay IDLE.
  - IDLE, start=1, MULT/MULTU: latch operands (abs values + sign for MULT); busy=1 after E0; counter=0; → MUL.
  - IDLE, start=1, DIV/DIVU with data2≠0: latch operands (abs values + signs for DIV); busy=1; → DIV.
  - IDLE, start=1, DIV/DIVU with data2=0: single-cycle completion at E0: hi=data1, lo=all ones, result=lo, div_by_zero=1, done pulse.
  - MUL: shift-add, one bit per clock. DIV: restoring, one quotient bit per clock.
  - Exit: at edge E_WIDTH (counter = WIDTH-1 at that edge), apply sign correction, write hi/lo, result=lo, zero=(lo==0), busy=0, done=1 for one cycle; → IDLE.
- Latency: single-cycle ops 1 clock; MULT/DIV exactly WIDTH clocks from accept to done.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT/SLTU produce 1 or 0, zero-extended.
  - MULT: {hi,lo} = full 2·WIDTH product.
  - DIV: quotient truncates toward zero into lo; remainder into hi, taking the sign of the dividend.
  - DIV of most-negative by −1: lo = most-negative, hi = 0; no flag.
- div_by_zero updates on every done: 1 only for the DIV/DIVU-by-zero case, otherwise 0.
- Handshake and state retention:
  - start while busy=1 is ignored; operands and op are not sampled.
  - start in the same cycle done=1 (busy=0) is accepted: back-to-back issue.
  - result, zero, hi and lo hold between operations.
  - Single-cycle ops never modify hi/lo.
  - MFHI/MFLO issued on the done cycle read the freshly written hi/lo.
- done is 0 in every cycle except the single completion cycle.

Test Plan:
- Reset mid-MULT: start MULT 7×9, deassert rst_n at cycle 5 → busy=0, hi=lo=0, zero=1, no done; re-issue after reset → lo=63 at cycle 32.
- Single-cycle ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → result=0, zero=1, done 1 cycle after start.
  - SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0.
  - NOR 0,0 → 0xFFFFFFFF.
- MULT −3×5 → busy high for 32 cycles, done at cycle 32, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → done next cycle, div_by_zero=1, hi=7, lo=0xFFFFFFFF; DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Handshake:
  - start=ADD asserted during a DIV → ignored.
  - Back-to-back: MFLO asserted on the DIV done cycle → accepted; next cycle result = quotient.
  - No done between.
